// File: rtl/common_pkg.sv
// Shared scalar types used across the pipeline.
package common;

    typedef logic [31:0] u32;

endpackage

// File: rtl/pipes_pkg.sv
// Inter-stage payload and state types for the front end of the pipeline.
package pipes;

    import common::*;

    typedef struct packed {
        u32 pc;
        u32 instruction;
    } fetch_data_t;

    typedef enum logic [1:0] {
        StReq   = 2'd0,
        StWait  = 2'd1,
        StOut   = 2'd2,
        StDrain = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding bus request at a time,
// applies delay-slot redirects and exception flushes, and hands instructions to decode.
module fetch_ctrl
    import common::*;
    import pipes::*;
#(
    parameter u32 RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output fetch_data_t out_data
);

    fetch_state_t state_q, state_d;
    u32           ireq_addr_q, ireq_addr_d;
    fetch_data_t  out_data_q, out_data_d;
    logic         pend_q, pend_d;
    u32           pend_target_q, pend_target_d;

    // ireq_addr_q also serves as the registered flush target.
    always_comb begin
        state_d       = state_q;
        ireq_addr_d   = ireq_addr_q;
        out_data_d    = out_data_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;

        if (redirect_valid) begin
            pend_d        = 1'b1;
            pend_target_d = redirect_target;
        end

        unique case (state_q)
            StReq: begin
                if (flush_valid) begin
                    pend_d      = 1'b0;
                    ireq_addr_d = flush_pc;
                    if (ireq_ready) state_d = StDrain;
                end else if (ireq_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (flush_valid) begin
                    pend_d      = 1'b0;
                    ireq_addr_d = flush_pc;
                    state_d     = iresp_valid ? StReq : StDrain;
                end else if (iresp_valid) begin
                    out_data_d = '{pc: ireq_addr, instruction: iresp_data};
                    state_d    = StOut;
                end
            end
            StOut: begin
                if (flush_valid) begin
                    pend_d      = 1'b0;
                    ireq_addr_d = flush_pc;
                    state_d     = StReq;
                end else if (out_ready) begin
                    state_d = StReq;
                    pend_d  = 1'b0;
                    // A redirect arriving on the handshake skips the pending slot entirely.
                    if (redirect_valid) begin
                        ireq_addr_d = redirect_target;
                    end else if (pend_q) begin
                        ireq_addr_d = pend_target_q;
                    end else begin
                        ireq_addr_d = out_data_q.pc + 32'd4;
                    end
                end
            end
            StDrain: begin
                if (flush_valid) begin
                    pend_d      = 1'b0;
                    ireq_addr_d = flush_pc;
                end
                if (iresp_valid) state_d = StReq;
            end
            default: state_d = StReq;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StReq;
            ireq_addr_q   <= RESET_PC;
            out_data_q    <= '0;
            pend_q        <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            ireq_addr_q   <= ireq_addr_d;
            out_data_q    <= out_data_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Held low while reset is asserted so the bus never sees a request during reset.
    assign ireq_valid = reset && (state_q == StReq);
    assign ireq_addr  = {ireq_addr_q[31:2], 2'b00};
    assign out_valid  = (state_q == StOut);
    assign out_data   = out_data_q;

    a_no_stray_resp: assert property (@(posedge clk) disable iff (!reset)
        !(iresp_valid && (state_q == StReq || state_q == StOut)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed cycle-by-cycle vectors for fetch_ctrl plus a hand-written async-reset sequence.
module tb_fetch_ctrl;
    import common::*;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready = 1'b0;
    logic        iresp_valid = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    fetch_data_t out_data;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .ireq_ready     (ireq_ready),
        .iresp_valid    (iresp_valid),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .flush_valid    (flush_valid),
        .flush_pc       (flush_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rtgt;
        logic        fl;
        logic [31:0] fpc;
        logic        ordy;
        logic        e_iv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] ins(input int k);
        return 32'h2400_0000 + k;
    endfunction

    task automatic add(input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic redir, input logic [31:0] rtgt,
                       input logic fl, input logic [31:0] fpc, input logic ordy,
                       input logic e_iv, input logic [31:0] e_addr,
                       input logic e_ov, input logic [31:0] e_pc, input logic [31:0] e_ins);
        vec_t v;
        v = '{rdy, rv, rdata, redir, rtgt, fl, fpc, ordy, e_iv, e_addr, e_ov, e_pc, e_ins};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic e_iv, input logic [31:0] e_addr,
                         input logic e_ov, input logic chk_data,
                         input logic [31:0] e_pc, input logic [31:0] e_ins);
        logic ok;
        ok = (ireq_valid === e_iv) && (ireq_addr === e_addr) && (out_valid === e_ov);
        if (chk_data) ok = ok && (out_data.pc === e_pc) && (out_data.instruction === e_ins);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got iv=%0b addr=%08h ov=%0b pc=%08h ins=%08h, want iv=%0b addr=%08h ov=%0b pc=%08h ins=%08h",
                     name, ireq_valid, ireq_addr, out_valid, out_data.pc, out_data.instruction,
                     e_iv, e_addr, e_ov, e_pc, e_ins);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rdata,
                         input logic redir, input logic [31:0] rtgt,
                         input logic fl, input logic [31:0] fpc, input logic ordy);
        ireq_ready      = rdy;
        iresp_valid     = rv;
        iresp_data      = rdata;
        redirect_valid  = redir;
        redirect_target = rtgt;
        flush_valid     = fl;
        flush_pc        = fpc;
        out_ready       = ordy;
    endtask

    initial begin
        //   rdy rv rdata   rdr rtgt          fl fpc            ordy iv addr          ov pc            ins
        add(1, 0, 0,       0, 0,            0, 0,            1,   1, 32'h0,        0, 0,            0);
        add(1, 1, ins(0),  0, 0,            0, 0,            1,   0, 32'h0,        0, 0,            0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   0, 32'h0,        1, 32'h0,        ins(0));
        add(1, 0, 0,       0, 0,            0, 0,            1,   1, 32'h4,        0, 0,            0);
        add(1, 1, ins(1),  0, 0,            0, 0,            1,   0, 32'h4,        0, 0,            0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   0, 32'h4,        1, 32'h4,        ins(1));
        add(1, 0, 0,       0, 0,            0, 0,            1,   1, 32'h8,        0, 0,            0);
        add(1, 0, 0,       1, 32'h100,      0, 0,            1,   0, 32'h8,        0, 0,            0);
        add(1, 1, ins(2),  0, 0,            0, 0,            1,   0, 32'h8,        0, 0,            0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   0, 32'h8,        1, 32'h8,        ins(2));
        add(1, 0, 0,       0, 0,            0, 0,            1,   1, 32'h100,      0, 0,            0);
        add(1, 1, ins(3),  0, 0,            0, 0,            1,   0, 32'h100,      0, 0,            0);
        add(1, 0, 0,       1, 32'h200,      0, 0,            1,   0, 32'h100,      1, 32'h100,      ins(3));
        add(1, 0, 0,       0, 0,            0, 0,            1,   1, 32'h200,      0, 0,            0);
        add(1, 1, ins(4),  0, 0,            0, 0,            1,   0, 32'h200,      0, 0,            0);
        // five-cycle stall; two redirects, the later one wins
        add(1, 0, 0,       0, 0,            0, 0,            0,   0, 32'h200,      1, 32'h200,      ins(4));
        add(1, 0, 0,       1, 32'h2f0,      0, 0,            0,   0, 32'h200,      1, 32'h200,      ins(4));
        add(1, 0, 0,       1, 32'h300,      0, 0,            0,   0, 32'h200,      1, 32'h200,      ins(4));
        add(1, 0, 0,       0, 0,            0, 0,            0,   0, 32'h200,      1, 32'h200,      ins(4));
        add(1, 0, 0,       0, 0,            0, 0,            0,   0, 32'h200,      1, 32'h200,      ins(4));
        add(1, 0, 0,       0, 0,            0, 0,            1,   0, 32'h200,      1, 32'h200,      ins(4));
        add(1, 0, 0,       0, 0,            0, 0,            1,   1, 32'h300,      0, 0,            0);
        // pending redirect then flush in WAIT; flush must clear it
        add(1, 0, 0,       1, 32'h400,      0, 0,            1,   0, 32'h300,      0, 0,            0);
        add(1, 0, 0,       0, 0,            1, 32'h380,      1,   0, 32'h300,      0, 0,            0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   0, 32'h380,      0, 0,            0);
        add(1, 1, ins(5),  0, 0,            0, 0,            1,   0, 32'h380,      0, 0,            0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   1, 32'h380,      0, 0,            0);
        add(1, 1, ins(6),  0, 0,            0, 0,            1,   0, 32'h380,      0, 0,            0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   0, 32'h380,      1, 32'h380,      ins(6));
        // bus back-pressure with a flush in the window
        add(0, 0, 0,       0, 0,            0, 0,            1,   1, 32'h384,      0, 0,            0);
        add(0, 0, 0,       0, 0,            0, 0,            1,   1, 32'h384,      0, 0,            0);
        add(0, 0, 0,       0, 0,            1, 32'h500,      1,   1, 32'h384,      0, 0,            0);
        add(0, 0, 0,       0, 0,            0, 0,            1,   1, 32'h500,      0, 0,            0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   1, 32'h500,      0, 0,            0);
        add(1, 1, ins(7),  0, 0,            0, 0,            1,   0, 32'h500,      0, 0,            0);
        add(1, 0, 0,       0, 0,            1, 32'h600,      1,   0, 32'h500,      1, 32'h500,      ins(7));
        add(1, 0, 0,       0, 0,            1, 32'h700,      1,   1, 32'h600,      0, 0,            0);
        add(1, 0, 0,       0, 0,            1, 32'h704,      1,   0, 32'h700,      0, 0,            0);
        add(1, 1, ins(8),  0, 0,            0, 0,            1,   0, 32'h704,      0, 0,            0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   1, 32'h704,      0, 0,            0);
        add(1, 1, ins(9),  0, 0,            1, 32'h800,      1,   0, 32'h704,      0, 0,            0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   1, 32'h800,      0, 0,            0);
        add(1, 1, ins(10), 0, 0,            0, 0,            1,   0, 32'h800,      0, 0,            0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   0, 32'h800,      1, 32'h800,      ins(10));
        // pc + 4 wraps past the top of the address space
        add(0, 0, 0,       0, 0,            1, 32'hffff_fffc, 1,  1, 32'h804,      0, 0,            0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   1, 32'hffff_fffc, 0, 0,           0);
        add(1, 1, ins(11), 0, 0,            0, 0,            1,   0, 32'hffff_fffc, 0, 0,           0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   0, 32'hffff_fffc, 1, 32'hffff_fffc, ins(11));
        add(0, 0, 0,       0, 0,            1, 32'h900,      1,   1, 32'h0,        0, 0,            0);
        add(1, 0, 0,       0, 0,            0, 0,            1,   1, 32'h900,      0, 0,            0);
        add(0, 0, 0,       0, 0,            0, 0,            1,   0, 32'h900,      0, 0,            0);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1 check("reset_state", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].redir, vecs[i].rtgt,
                  vecs[i].fl, vecs[i].fpc, vecs[i].ordy);
            #1 check($sformatf("vec%0d", i), vecs[i].e_iv, vecs[i].e_addr, vecs[i].e_ov,
                     vecs[i].e_ov, vecs[i].e_pc, vecs[i].e_ins);
        end

        // Async reset while a request to 0x900 is outstanding
        #3 reset = 1'b0;
        #1 check("reset_mid_wait", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        #1 check("reset_release_req", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        drive(1, 1, ins(20), 0, 0, 0, 0, 1);
        #1 check("post_reset_wait", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        #1 check("post_reset_out", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, ins(20));
        @(negedge clk);
        #1 check("post_reset_next", 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
